// File: rtl/serial_adder_pkg.sv
// Shared FSM state encoding and default operand width for serial_adder.
package serial_adder_pkg;
    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fulladder.sv
// 1-bit full adder; the per-bit datapath of serial_adder.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, result registered on entry to DONE.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Overflow
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    fulladder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .Sum  (fa_s),
        .Cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (Start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (Start) begin
                    a_sh  <= A;
                    b_sh  <= B;
                    carry <= Cin;
                    cnt   <= '0;
                end
                RUN: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        Sum  <= {fa_s, res_sh[WIDTH-1:1]};
                        Cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // In the last RUN cycle the shifters hold the original operand MSBs
                        Overflow <= (a_sh[0] == b_sh[0]) && (fa_s != a_sh[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);
endmodule
